// File: rtl/control_mc.sv
// Multicycle control unit for the accumulator CPU.
// Moore-style controller: strobes, mux selects and ALU op are decoded from the
// state register and the memory wait counter. The only exceptions are
// o_illegal in DECODE and the OP_WB ACC/ALU selects, which read the opcode.
// Memory-access states stretch to 1+MEM_WAIT cycles.
module control_mc #(
    parameter int OPW      = 8,
    parameter int ALUW     = 2,
    parameter int MEM_WAIT = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [OPW-1:0]  i_opcode,
    input  logic            i_acc_zero,
    input  logic            i_run,
    output logic            o_mem_rw,
    output logic            o_ld_mdr,
    output logic            o_ld_mar,
    output logic            o_ld_pc,
    output logic            o_ld_acc,
    output logic            o_ld_ir,
    output logic            o_mux_PC_to_ir_p1,
    output logic            o_mux_ACC_to_mdr_alur,
    output logic            o_mux_MAR_to_pc_ird,
    output logic            o_mux_MDR_to_mem_acc,
    output logic [ALUW-1:0] o_alu_ctrl,
    output logic            o_halted,
    output logic            o_illegal,
    output logic [3:0]      o_state
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH_ADDR = 4'd1,
        S_FETCH_MEM  = 4'd2,
        S_FETCH_IR   = 4'd3,
        S_DECODE     = 4'd4,
        S_OP_ADDR    = 4'd5,
        S_OP_MEM     = 4'd6,
        S_OP_WB      = 4'd7,
        S_ST_ADDR    = 4'd8,
        S_ST_DATA    = 4'd9,
        S_ST_WR      = 4'd10,
        S_JUMP       = 4'd11,
        S_INC        = 4'd12,
        S_HALT       = 4'd13
    } state_t;

    localparam logic [2:0] OP_NOOP = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_JZ   = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STA  = 3'd6;
    localparam logic [2:0] OP_HLT  = 3'd7;

    localparam logic [3:0]      WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [ALUW-1:0] ALU_ADD   = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_XOR   = ALUW'(1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [2:0] op_s;
    logic       op_bad_s;
    logic       mem_last_s;

    assign op_s       = i_opcode[2:0];
    // Any set bit above the 3-bit opcode field makes the instruction unmapped.
    assign op_bad_s   = (i_opcode >> 3) != {OPW{1'b0}};
    assign mem_last_s = (cnt_q == WAIT_LAST);

    // Next-state and wait-counter logic; the counter is zero on entry to a memory state.
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            S_RESET:      state_d = S_FETCH_ADDR;
            S_FETCH_ADDR: state_d = S_FETCH_MEM;
            S_FETCH_MEM: begin
                if (mem_last_s) begin
                    state_d = S_FETCH_IR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FETCH_IR:   state_d = S_DECODE;
            S_DECODE: begin
                if (op_bad_s) begin
                    state_d = S_INC;
                end else begin
                    case (op_s)
                        OP_NOOP: state_d = S_INC;
                        OP_ADD,
                        OP_XOR,
                        OP_LDA:  state_d = S_OP_ADDR;
                        OP_JMP:  state_d = S_JUMP;
                        OP_JZ:   state_d = i_acc_zero ? S_JUMP : S_INC;
                        OP_STA:  state_d = S_ST_ADDR;
                        OP_HLT:  state_d = S_HALT;
                        default: state_d = S_INC;
                    endcase
                end
            end
            S_OP_ADDR:    state_d = S_OP_MEM;
            S_OP_MEM: begin
                if (mem_last_s) begin
                    state_d = S_OP_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_OP_WB:      state_d = S_INC;
            S_ST_ADDR:    state_d = S_ST_DATA;
            S_ST_DATA:    state_d = S_ST_WR;
            S_ST_WR: begin
                if (mem_last_s) begin
                    state_d = S_INC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_JUMP:       state_d = S_FETCH_ADDR;
            S_INC:        state_d = S_FETCH_ADDR;
            S_HALT:       state_d = i_run ? S_INC : S_HALT;
            default:      state_d = S_RESET;
        endcase
    end

    // Output decode from the current state; unlisted strobes and selects stay 0.
    always_comb begin
        o_mem_rw              = 1'b0;
        o_ld_mdr              = 1'b0;
        o_ld_mar              = 1'b0;
        o_ld_pc               = 1'b0;
        o_ld_acc              = 1'b0;
        o_ld_ir               = 1'b0;
        o_mux_PC_to_ir_p1     = 1'b0;
        o_mux_ACC_to_mdr_alur = 1'b0;
        o_mux_MAR_to_pc_ird   = 1'b0;
        o_mux_MDR_to_mem_acc  = 1'b0;
        o_alu_ctrl            = ALU_ADD;
        o_halted              = 1'b0;
        o_illegal             = 1'b0;
        case (state_q)
            S_FETCH_ADDR: o_ld_mar = 1'b1;
            S_FETCH_MEM:  o_ld_mdr = mem_last_s;
            S_FETCH_IR:   o_ld_ir  = 1'b1;
            S_DECODE:     o_illegal = op_bad_s;
            S_OP_ADDR: begin
                o_ld_mar            = 1'b1;
                o_mux_MAR_to_pc_ird = 1'b1;
            end
            S_OP_MEM:     o_ld_mdr = mem_last_s;
            S_OP_WB: begin
                o_ld_acc = 1'b1;
                case (op_s)
                    OP_ADD:  o_mux_ACC_to_mdr_alur = 1'b1;
                    OP_XOR: begin
                        o_mux_ACC_to_mdr_alur = 1'b1;
                        o_alu_ctrl            = ALU_XOR;
                    end
                    default: o_mux_ACC_to_mdr_alur = 1'b0;
                endcase
            end
            S_ST_ADDR: begin
                o_ld_mar            = 1'b1;
                o_mux_MAR_to_pc_ird = 1'b1;
            end
            S_ST_DATA: begin
                o_ld_mdr             = 1'b1;
                o_mux_MDR_to_mem_acc = 1'b1;
            end
            S_ST_WR:      o_mem_rw = 1'b1;
            S_JUMP:       o_ld_pc  = 1'b1;
            S_INC: begin
                o_ld_pc           = 1'b1;
                o_mux_PC_to_ir_p1 = 1'b1;
            end
            S_HALT:       o_halted = 1'b1;
            default:      o_halted = 1'b0;
        endcase
    end

    assign o_state = state_q;

    // State and wait-counter registers; reset aborts any instruction immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_RESET;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_control_mc.sv
// Scoreboard bench for control_mc: stimulus pushes hand-written per-cycle
// expectations (state + all outputs); a negedge monitor pops and compares.
// Two instances share inputs: MEM_WAIT=0 (u0) and MEM_WAIT=2 (u2).
module tb_control_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] opcode;
    logic       acc_zero;
    logic       run;

    logic       rw0, mdr0, mar0, pc0, acc0, ir0, mpc0, macc0, mmar0, mmdr0, hlt0, ill0;
    logic [1:0] alu0;
    logic [3:0] st0;
    logic       rw2, mdr2, mar2, pc2, acc2, ir2, mpc2, macc2, mmar2, mmdr2, hlt2, ill2;
    logic [1:0] alu2;
    logic [3:0] st2;

    always #5 clk = ~clk;

    control_mc #(.OPW(8), .ALUW(2), .MEM_WAIT(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_acc_zero(acc_zero), .i_run(run),
        .o_mem_rw(rw0), .o_ld_mdr(mdr0), .o_ld_mar(mar0), .o_ld_pc(pc0), .o_ld_acc(acc0),
        .o_ld_ir(ir0), .o_mux_PC_to_ir_p1(mpc0), .o_mux_ACC_to_mdr_alur(macc0),
        .o_mux_MAR_to_pc_ird(mmar0), .o_mux_MDR_to_mem_acc(mmdr0), .o_alu_ctrl(alu0),
        .o_halted(hlt0), .o_illegal(ill0), .o_state(st0)
    );

    control_mc #(.OPW(8), .ALUW(2), .MEM_WAIT(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_acc_zero(acc_zero), .i_run(run),
        .o_mem_rw(rw2), .o_ld_mdr(mdr2), .o_ld_mar(mar2), .o_ld_pc(pc2), .o_ld_acc(acc2),
        .o_ld_ir(ir2), .o_mux_PC_to_ir_p1(mpc2), .o_mux_ACC_to_mdr_alur(macc2),
        .o_mux_MAR_to_pc_ird(mmar2), .o_mux_MDR_to_mem_acc(mmdr2), .o_alu_ctrl(alu2),
        .o_halted(hlt2), .o_illegal(ill2), .o_state(st2)
    );

    // Output flag bits: {rw, ld_mdr, ld_mar, ld_pc, ld_acc, ld_ir,
    //                    mux_pc, mux_acc, mux_mar, mux_mdr, alu[1:0], halted, illegal}
    localparam logic [13:0] F_NONE = 14'h0000;
    localparam logic [13:0] F_RW   = 14'h2000;
    localparam logic [13:0] F_MDR  = 14'h1000;
    localparam logic [13:0] F_MAR  = 14'h0800;
    localparam logic [13:0] F_PC   = 14'h0400;
    localparam logic [13:0] F_ACC  = 14'h0200;
    localparam logic [13:0] F_IR   = 14'h0100;
    localparam logic [13:0] F_MPC  = 14'h0080;
    localparam logic [13:0] F_MACC = 14'h0040;
    localparam logic [13:0] F_MMAR = 14'h0020;
    localparam logic [13:0] F_MMDR = 14'h0010;
    localparam logic [13:0] F_XOR  = 14'h0004;
    localparam logic [13:0] F_HALT = 14'h0002;
    localparam logic [13:0] F_ILL  = 14'h0001;

    logic [17:0] vec0, vec2;
    assign vec0 = {st0, rw0, mdr0, mar0, pc0, acc0, ir0, mpc0, macc0, mmar0, mmdr0, alu0, hlt0, ill0};
    assign vec2 = {st2, rw2, mdr2, mar2, pc2, acc2, ir2, mpc2, macc2, mmar2, mmdr2, alu2, hlt2, ill2};

    typedef struct {
        int          dut;
        logic [17:0] exp;
        string       name;
    } item_t;

    item_t       sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [17:0] mon_act;

    // Monitor: one expected record per cycle, checked mid-cycle on the falling edge.
    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it      = sb.pop_front();
            mon_act = (it.dut == 2) ? vec2 : vec0;
            total++;
            if (mon_act !== it.exp) begin
                bad++;
                $display("FAIL %s (u%0d): got state=%0d flags=%h, want state=%0d flags=%h",
                         it.name, it.dut, mon_act[17:14], mon_act[13:0], it.exp[17:14], it.exp[13:0]);
            end
        end
    end

    task automatic push(input int d, input string nm, input logic [3:0] st, input logic [13:0] f);
        item_t it;
        it.dut  = d;
        it.exp  = {st, f};
        it.name = nm;
        sb.push_back(it);
    endtask

    // FETCH_ADDR, FETCH_MEM x (w+1) with ld_mdr on the last, FETCH_IR.
    task automatic push_fetch(input int d, input int w);
        push(d, "fetch_addr", 4'd1, F_MAR);
        for (int i = 0; i <= w; i++) begin
            push(d, "fetch_mem", 4'd2, (i == w) ? F_MDR : F_NONE);
        end
        push(d, "fetch_ir", 4'd3, F_IR);
    endtask

    // ADD/XOR/LDA path: DECODE, OP_ADDR, OP_MEM x (w+1), OP_WB, INC.
    task automatic push_alu(input int d, input int w, input logic [13:0] wb, input string nm);
        push_fetch(d, w);
        push(d, "decode", 4'd4, F_NONE);
        push(d, "op_addr", 4'd5, F_MAR | F_MMAR);
        for (int i = 0; i <= w; i++) begin
            push(d, "op_mem", 4'd6, (i == w) ? F_MDR : F_NONE);
        end
        push(d, nm, 4'd7, wb);
        push(d, "inc", 4'd12, F_PC | F_MPC);
    endtask

    // Let the monitor drain the queue; returns 1 time unit after a rising edge.
    task automatic wait_empty;
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 200);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 8'h00;
        acc_zero = 1'b0;
        run      = 1'b0;

        // Reset state, MEM_WAIT=0 instance.
        push(0, "reset", 4'd0, F_NONE);
        wait_empty();
        rst = 1'b0;

        // NOOP: 0,1,2,3,4,12 then next fetch.
        push(0, "rst_idle", 4'd0, F_NONE);
        push_fetch(0, 0);
        push(0, "decode", 4'd4, F_NONE);
        push(0, "noop_inc", 4'd12, F_PC | F_MPC);
        wait_empty();

        opcode = 8'h01;
        push_alu(0, 0, F_ACC | F_MACC, "add_wb");
        wait_empty();

        opcode = 8'h02;
        push_alu(0, 0, F_ACC | F_MACC | F_XOR, "xor_wb");
        wait_empty();

        opcode = 8'h05;
        push_alu(0, 0, F_ACC, "lda_wb");
        wait_empty();

        opcode = 8'h03;
        push_fetch(0, 0);
        push(0, "decode", 4'd4, F_NONE);
        push(0, "jmp_jump", 4'd11, F_PC);
        wait_empty();

        opcode   = 8'h04;
        acc_zero = 1'b1;
        push_fetch(0, 0);
        push(0, "decode", 4'd4, F_NONE);
        push(0, "jz_taken", 4'd11, F_PC);
        wait_empty();

        acc_zero = 1'b0;
        push_fetch(0, 0);
        push(0, "decode", 4'd4, F_NONE);
        push(0, "jz_not_taken", 4'd12, F_PC | F_MPC);
        wait_empty();

        opcode = 8'h09;
        push_fetch(0, 0);
        push(0, "illegal_decode", 4'd4, F_ILL);
        push(0, "illegal_inc", 4'd12, F_PC | F_MPC);
        wait_empty();

        // HLT held with run low, then released.
        opcode = 8'h07;
        push_fetch(0, 0);
        push(0, "decode", 4'd4, F_NONE);
        for (int i = 0; i < 10; i++) begin
            push(0, "halt_hold", 4'd13, F_HALT);
        end
        wait_empty();
        run = 1'b1;
        push(0, "halt_release", 4'd13, F_HALT);
        push(0, "halt_inc", 4'd12, F_PC | F_MPC);
        push(0, "after_halt", 4'd1, F_MAR);
        wait_empty();
        run = 1'b0;

        // MEM_WAIT=2 instance: fresh reset, then STA.
        rst = 1'b1;
        push(2, "reset_b", 4'd0, F_NONE);
        wait_empty();
        rst    = 1'b0;
        opcode = 8'h06;
        push(2, "rst_idle_b", 4'd0, F_NONE);
        push_fetch(2, 2);
        push(2, "decode", 4'd4, F_NONE);
        push(2, "st_addr", 4'd8, F_MAR | F_MMAR);
        push(2, "st_data", 4'd9, F_MDR | F_MMDR);
        for (int i = 0; i < 3; i++) begin
            push(2, "st_wr", 4'd10, F_RW);
        end
        push(2, "sta_inc", 4'd12, F_PC | F_MPC);
        wait_empty();

        // ADD interrupted by async reset during the last OP_MEM cycle.
        opcode = 8'h01;
        push_fetch(2, 2);
        push(2, "decode", 4'd4, F_NONE);
        push(2, "op_addr", 4'd5, F_MAR | F_MMAR);
        push(2, "op_mem", 4'd6, F_NONE);
        push(2, "op_mem", 4'd6, F_NONE);
        wait_empty();
        rst = 1'b1;
        push(2, "async_abort", 4'd0, F_NONE);
        wait_empty();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
- Parametrised multicycle control unit for the accumulator CPU. It is the successor to the fixed-timing fetch/execute controller.
- Drives load strobes, datapath mux selects, ALU op and memory R/W.
- Adds over the previous generation:
  - conditional jump on zero (JZ), load (LDA), store (STA) and halt (HLT);
  - configurable memory wait states;
  - illegal-opcode flagging;
  - a debug state output.
- Sits between the IR opcode field / ACC zero flag and the datapath registers PC, MAR, MDR, IR, ACC.

Parameters:
- OPW, 8, opcode width; opcode taken from i_opcode[2:0], upper bits must be zero else illegal.
- ALUW, 2, width of o_alu_ctrl.
- MEM_WAIT, 0, extra wait cycles per memory access (0..15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_opcode  in  OPW  IR opcode field; stable from the cycle after FETCH_IR.
- i_acc_zero  in  1  ACC==0 flag.
- i_run  in  1  level; releases HALT.
- o_mem_rw  out  1  1 = memory write, 0 = read.
- o_ld_mdr, o_ld_mar, o_ld_pc, o_ld_acc, o_ld_ir  out  1 each  register load strobes.
- o_mux_PC_to_ir_p1  out  1  PC source: 0 = IR operand, 1 = PC+1.
- o_mux_ACC_to_mdr_alur  out  1  ACC source: 0 = MDR, 1 = ALU result.
- o_mux_MAR_to_pc_ird  out  1  MAR source: 0 = PC, 1 = IR operand.
- o_mux_MDR_to_mem_acc  out  1  MDR source: 0 = memory, 1 = ACC.
- o_alu_ctrl  out  ALUW  ALU op: 0 = ADD, 1 = XOR.
- o_halted  out  1  high in HALT.
- o_illegal  out  1  one-cycle pulse on unmapped opcode.
- o_state  out  4  current state encoding (debug).

Behaviour:
- Opcodes: NOOP=0, ADD=1, XOR=2, JMP=3, JZ=4, LDA=5, STA=6, HLT=7.
- Moore machine: all outputs decode from the state register plus wait counter. Any strobe/mux not listed for a state is 0.
- Reset: async to RESET(0). All outputs 0, wait counter 0.
  - Reset mid-instruction aborts immediately; no partial strobes survive.
- State sequence and per-state outputs:
  - RESET(0): -> FETCH_ADDR.
  - FETCH_ADDR(1): ld_mar=1, MAR mux 0 -> FETCH_MEM.
  - FETCH_MEM(2): memory read wait; ld_mdr=1 on last cycle only -> FETCH_IR.
  - FETCH_IR(3): ld_ir=1 -> DECODE.
  - DECODE(4): branch on opcode:
    - NOOP -> INC.
    - ADD/XOR/LDA -> OP_ADDR.
    - JMP -> JUMP.
    - JZ -> JUMP if i_acc_zero=1 (sampled this cycle), else INC.
    - STA -> ST_ADDR.
    - HLT -> HALT.
    - Illegal: o_illegal=1 this cycle -> INC.
  - OP_ADDR(5): ld_mar=1, MAR mux 1 -> OP_MEM.
  - OP_MEM(6): wait; ld_mdr=1 on last cycle -> OP_WB.
  - OP_WB(7): ld_acc=1; ACC mux 1 for ADD/XOR, 0 for LDA; o_alu_ctrl decoded (ADD 0, XOR 1, LDA 0) -> INC.
  - ST_ADDR(8): ld_mar=1, MAR mux 1 -> ST_DATA.
  - ST_DATA(9): ld_mdr=1, MDR mux 1 -> ST_WR.
  - ST_WR(10): o_mem_rw=1 for the whole duration -> INC.
  - JUMP(11): ld_pc=1, PC mux 0 -> FETCH_ADDR.
  - INC(12): ld_pc=1, PC mux 1 -> FETCH_ADDR.
  - HALT(13): o_halted=1; stays while i_run=0; i_run=1 -> INC.
  - States 14, 15: -> RESET.
- Memory states (FETCH_MEM, OP_MEM, ST_WR) each last 1+MEM_WAIT cycles.
  - Counter clears on entry and increments each cycle; exit when count==MEM_WAIT.
- Cycle counts, fetch to next FETCH_ADDR, with MEM_WAIT=0:
  - NOOP, JMP, JZ: 5.
  - ADD, XOR, LDA, STA: 8.
  - Add MEM_WAIT per memory state traversed.
- i_opcode and i_acc_zero are only sampled in DECODE and OP_WB; ignored elsewhere.
- At most one ld_* strobe is high in any cycle.

Test Plan:
- Reset release, opcode NOOP, MEM_WAIT=0 -> o_state sequence 0,1,2,3,4,12,1; ld_pc=1 with PC mux 1 only in state 12.
- ADD then XOR -> OP_WB asserts ld_acc=1, ACC mux=1, alu_ctrl=0 then 1; 8 cycles per instruction; LDA gives ACC mux=0.
- JZ with i_acc_zero=1 -> JUMP, ld_pc=1 with PC mux 0. JZ with i_acc_zero=0 -> INC. Both take 5 cycles.
- STA with MEM_WAIT=2 -> ST_DATA asserts ld_mdr with MDR mux 1; o_mem_rw=1 for exactly 3 cycles; FETCH_MEM lasts 3 cycles with ld_mdr only on the 3rd.
- HLT -> o_halted=1 held 10 cycles with i_run=0. i_run=1 -> INC next cycle, then FETCH_ADDR.
- Opcode 8'h09 -> o_illegal one-cycle pulse in DECODE, then INC. Async reset asserted mid-OP_MEM -> all outputs 0 before the next clock edge, o_state=0.
